// File: rtl/ps2_multi_joypad.sv
// PS/2 keyboard to NES joypad mapper: keyboard init (FF/ED/00 with timeout, retry and FE resend)
// plus a host-writable key map. Optional PS2_EXT_KEYS_EN makes E0-prefixed codes distinct keys.
module ps2_multi_joypad #(
    parameter int NUM_PADS    = 2,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_scan_val,
    input  logic [7:0]                      i_scancode,
    input  logic                            i_ready,
    output logic                            o_cmd_val,
    output logic [7:0]                      o_cmd,
    input  logic                            i_map_we,
    input  logic [$clog2(NUM_PADS*10)-1:0]  i_map_addr,
    input  logic [8:0]                      i_map_code,
    output logic [NUM_PADS*10-1:0]          o_jp_vector,
    output logic                            o_initdone,
    output logic                            o_init_err
);
    localparam int NUM_ENT = NUM_PADS * 10;
    localparam int TW      = $clog2(TIMEOUT_CYC + 1);
    localparam int RW      = $clog2(MAX_RETRY + 1) + 1;

    typedef enum logic [3:0] {
        S_SEND_FF, S_RDY_FF, S_ACK_FF, S_WAIT_AA,
        S_PRE_ED,  S_SEND_ED, S_RDY_ED, S_ACK_ED,
        S_PRE_00,  S_SEND_00, S_RDY_00, S_ACK_00,
        S_PRE_DN,  S_DONE,    S_FAIL
    } state_t;

    state_t              r_state, w_nxt;
    logic [TW-1:0]       r_tmo;
    logic [RW-1:0]       r_retry;
    logic                r_done, r_err, r_rel, r_ext;
    logic [8:0]          r_map [NUM_ENT];
    logic [NUM_ENT-1:0]  r_jp, w_match;
    logic                w_fa, w_aa, w_fe, w_wait_st, w_tmo_hit, w_retry_last, w_cand;

    function automatic logic [8:0] f_def(input int idx);
        case (idx)
            0:  f_def = 9'h01D;  1: f_def = 9'h01B;  2: f_def = 9'h01C;  3: f_def = 9'h023;
            4:  f_def = 9'h03B;  5: f_def = 9'h042;  6: f_def = 9'h03C;  7: f_def = 9'h043;
            8:  f_def = 9'h02A;  9: f_def = 9'h032;
            10: f_def = 9'h075; 11: f_def = 9'h072; 12: f_def = 9'h06B; 13: f_def = 9'h074;
            14: f_def = 9'h03A; 15: f_def = 9'h041; 16: f_def = 9'h04B; 17: f_def = 9'h04C;
            18: f_def = 9'h059; 19: f_def = 9'h05A;
            default: f_def = 9'h000;
        endcase
    endfunction

    assign w_fa = i_scan_val && (i_scancode == 8'hFA);
    assign w_aa = i_scan_val && (i_scancode == 8'hAA);
    assign w_fe = i_scan_val && (i_scancode == 8'hFE);
    assign w_wait_st = (r_state == S_ACK_FF) || (r_state == S_WAIT_AA) ||
                       (r_state == S_ACK_ED) || (r_state == S_ACK_00);
    assign w_retry_last = (r_retry >= RW'(MAX_RETRY - 1));

    always_comb begin
        w_nxt     = r_state;
        o_cmd_val = 1'b0;
        o_cmd     = 8'h00;
        w_tmo_hit = 1'b0;
        case (r_state)
            S_SEND_FF: if (i_ready) begin o_cmd_val = 1'b1; o_cmd = 8'hFF; w_nxt = S_RDY_FF; end
            S_RDY_FF:  if (i_ready) w_nxt = S_ACK_FF;
            S_ACK_FF:  if (w_fa) w_nxt = S_WAIT_AA; else if (w_fe) w_nxt = S_SEND_FF;
            S_WAIT_AA: if (w_aa) w_nxt = S_PRE_ED;
            S_PRE_ED:  if (i_ready) w_nxt = S_SEND_ED;
            S_SEND_ED: begin o_cmd_val = 1'b1; o_cmd = 8'hED; w_nxt = S_RDY_ED; end
            S_RDY_ED:  if (i_ready) w_nxt = S_ACK_ED;
            S_ACK_ED:  if (w_fa) w_nxt = S_PRE_00; else if (w_fe) w_nxt = S_PRE_ED;
            S_PRE_00:  if (i_ready) w_nxt = S_SEND_00;
            S_SEND_00: begin o_cmd_val = 1'b1; o_cmd = 8'h00; w_nxt = S_RDY_00; end
            S_RDY_00:  if (i_ready) w_nxt = S_ACK_00;
            S_ACK_00:  if (w_fa) w_nxt = S_PRE_DN; else if (w_fe) w_nxt = S_PRE_00;
            S_PRE_DN:  if (i_ready) w_nxt = S_DONE;
            S_DONE, S_FAIL: if (w_aa) w_nxt = S_PRE_ED;
            default:   w_nxt = S_SEND_FF;
        endcase
        // Timeout outranks any byte arriving on the same cycle.
        if (w_wait_st && (r_tmo == TW'(TIMEOUT_CYC - 1))) begin
            w_tmo_hit = 1'b1;
            w_nxt     = w_retry_last ? S_FAIL : S_SEND_FF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_SEND_FF;
            r_tmo   <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state)
                r_tmo <= '0;
            else if (w_wait_st)
                r_tmo <= r_tmo + TW'(1);
            if (w_nxt == S_DONE && r_state != S_DONE) begin
                r_retry <= '0;
                r_err   <= 1'b0;
                r_done  <= 1'b1;
            end else if (w_tmo_hit && !w_retry_last) begin
                r_retry <= r_retry + RW'(1);
            end
            if (w_nxt == S_FAIL && r_state != S_FAIL)
                r_err <= 1'b1;
        end
    end

    // Protocol bytes and prefixes never take part in matching.
    assign w_cand = !(i_scancode inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hF0, 8'hE0});

    // w_match is indexed by vector bit: entry k of a pad drives bit 9-k of that pad.
    for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
        localparam int BIT = (g / 10) * 10 + 9 - (g % 10);
        assign w_match[BIT] = w_cand && (r_map[g][7:0] == i_scancode) &&
                              (r_map[g][7:0] != 8'h00) && (r_map[g][8] == r_ext);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_jp  <= '0;
            r_rel <= 1'b0;
            r_ext <= 1'b0;
            for (int i = 0; i < NUM_ENT; i++) r_map[i] <= f_def(i);
        end else begin
            if (i_map_we && (int'(i_map_addr) < NUM_ENT))
                r_map[i_map_addr] <= i_map_code;
            if (r_state == S_DONE && w_nxt != S_DONE) begin
                r_jp  <= '0;
                r_rel <= 1'b0;
                r_ext <= 1'b0;
            end else if (r_state == S_DONE && i_scan_val) begin
                case (i_scancode)
                    8'hF0: r_rel <= 1'b1;
`ifdef PS2_EXT_KEYS_EN
                    8'hE0: r_ext <= 1'b1;
`else
                    8'hE0: r_ext <= 1'b0;
`endif
                    default: begin
                        for (int b = 0; b < NUM_ENT; b++)
                            if (w_match[b]) r_jp[b] <= ~r_rel;
                        r_rel <= 1'b0;
                        r_ext <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_jp_vector = r_jp;
    assign o_initdone  = r_done;
    assign o_init_err  = r_err;
endmodule
